// File: rtl/zmenu_overlay_render.sv
// -----------------------------------------------------------------------------
// zmenu_overlay_render
//   Pixel-stream overlay that draws the 11-item settings menu bar on the
//   480x272 TFT. Every pixel passes through with a fixed 2-cycle latency and
//   is recoloured when it falls inside a menu item body.
//
//   Colour priority inside an item: cursor (yellow) > selected (green) >
//   plain item (gray). Outside items the background is passed through.
//   Item map: 0..4 = PERIOD1..5, 5..8 = DIV0/2/4/8, 9..10 = spare.
//
//   Optional build macro ZMENU_BLINK_EN: when defined, the cursor blinks
//   with a half-period of BLINK_FRAMES frames; when undefined, no blink
//   counter is built and the cursor is always drawn.
//
// Ports:
//   clk                         pixel clock
//   rst                         synchronous active-high reset
//   en                          overlay enable, 0 = pass-through
//   iFrame_Start                one-cycle pulse before first pixel of a frame
//   iPixel_Valid/X/Y            pixel qualifier and coordinates
//   iBack_Color                 underlying RGB565 pixel
//   iCursor_Index               menu cursor (snapshotted on iFrame_Start)
//   iActive_Periods_Num         selected period code (snapshotted)
//   iPulseCounter_Gain_Divider  divider code (snapshotted)
//   oPixel_Valid                iPixel_Valid delayed 2 cycles
//   oPixel_Color                output RGB565
//   oIn_Menu                    pixel lies inside an item body
// -----------------------------------------------------------------------------
module zmenu_overlay_render #(
   parameter int MENU_X       = 16,
   parameter int MENU_Y       = 240,
   parameter int ITEM_W       = 40,
   parameter int ITEM_H       = 24,
   parameter int ITEM_GAP     = 4,
   parameter int NUM_ITEMS    = 11,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        iFrame_Start,
   input  logic        iPixel_Valid,
   input  logic [9:0]  iPixel_X,
   input  logic [9:0]  iPixel_Y,
   input  logic [15:0] iBack_Color,
   input  logic [3:0]  iCursor_Index,
   input  logic [2:0]  iActive_Periods_Num,
   input  logic [1:0]  iPulseCounter_Gain_Divider,
   output logic        oPixel_Valid,
   output logic [15:0] oPixel_Color,
   output logic        oIn_Menu
);

   localparam logic [15:0] COLOR_CURSOR = 16'hFFE0;
   localparam logic [15:0] COLOR_SEL    = 16'h07E0;
   localparam logic [15:0] COLOR_ITEM   = 16'h8410;

   // ---------------------------------------------------------------------
   // Frame snapshot of the menu state, so a frame never tears mid-scan.
   // ---------------------------------------------------------------------
   logic [3:0] cursor_q;
   logic [2:0] period_q;
   logic [1:0] divider_q;
   logic       cursor_vis;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) begin
         cursor_q  <= 4'hF;
         period_q  <= 3'd0;
         divider_q <= 2'd0;
      end else if (iFrame_Start) begin
         cursor_q  <= iCursor_Index;
         period_q  <= iActive_Periods_Num;
         divider_q <= iPulseCounter_Gain_Divider;
      end
   end

`ifdef ZMENU_BLINK_EN
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CNT_W-1:0] blink_cnt;
   logic             blink_phase;
   logic             cursor_vis_q;

   // The frame draws with the phase as it stood before this frame's pulse
   // advanced the counter, giving exactly BLINK_FRAMES visible frames first.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         blink_cnt    <= '0;
         blink_phase  <= 1'b1;
         cursor_vis_q <= 1'b1;
      end else if (iFrame_Start) begin
         cursor_vis_q <= blink_phase;
         if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign cursor_vis = cursor_vis_q;
`else
   assign cursor_vis = 1'b1;
`endif

   // ---------------------------------------------------------------------
   // Stage 1: item hit and index via compare chain against constant bounds.
   // ---------------------------------------------------------------------
   logic [31:0] px_w;
   logic [31:0] py_w;
   logic        hit_c;
   logic [3:0]  k_c;

   assign px_w = 32'(iPixel_X);
   assign py_w = 32'(iPixel_Y);

   // NOTE: every always_comb output gets a default before any condition,
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      hit_c = 1'b0;
      k_c   = 4'd0;
      if (py_w >= 32'(MENU_Y) && py_w <= 32'(MENU_Y + ITEM_H - 1)) begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            if (px_w >= 32'(MENU_X + i * ITEM_W) &&
                px_w <= 32'(MENU_X + i * ITEM_W + ITEM_W - ITEM_GAP - 1)) begin
               hit_c = 1'b1;
               k_c   = 4'(i);
            end
         end
      end
   end

   logic        valid_s1;
   logic [15:0] back_s1;
   logic        hit_s1;
   logic [3:0]  k_s1;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_s1 <= 1'b0;
         back_s1  <= 16'h0000;
         hit_s1   <= 1'b0;
         k_s1     <= 4'd0;
      end else begin
         valid_s1 <= iPixel_Valid;
         back_s1  <= iBack_Color;
         hit_s1   <= hit_c & en;
         k_s1     <= k_c;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: colour priority.
   // ---------------------------------------------------------------------
   logic        is_cursor;
   logic        is_sel;
   logic [15:0] color_c;

   // Period codes 5..7 must not alias onto the divider items 5..7.
   assign is_cursor = (cursor_q < 4'(NUM_ITEMS)) && (k_s1 == cursor_q) && cursor_vis;
   assign is_sel    = ((period_q <= 3'd4) && (k_s1 == {1'b0, period_q})) ||
                      (k_s1 == (4'd5 + {2'b00, divider_q}));

   always_comb begin
      color_c = back_s1;
      if (hit_s1) begin
         if (is_cursor)   color_c = COLOR_CURSOR;
         else if (is_sel) color_c = COLOR_SEL;
         else             color_c = COLOR_ITEM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         oPixel_Valid <= 1'b0;
         oPixel_Color <= 16'h0000;
         oIn_Menu     <= 1'b0;
      end else begin
         oPixel_Valid <= valid_s1;
         oPixel_Color <= color_c;
         oIn_Menu     <= hit_s1;
      end
   end

endmodule

// File: tb/tb_zmenu_overlay_render.sv
module tb_zmenu_overlay_render;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        iFrame_Start;
   logic        iPixel_Valid;
   logic [9:0]  iPixel_X;
   logic [9:0]  iPixel_Y;
   logic [15:0] iBack_Color;
   logic [3:0]  iCursor_Index;
   logic [2:0]  iActive_Periods_Num;
   logic [1:0]  iPulseCounter_Gain_Divider;
   logic        oPixel_Valid;
   logic [15:0] oPixel_Color;
   logic        oIn_Menu;

   int total = 0;
   int bad   = 0;

   zmenu_overlay_render #(.BLINK_FRAMES(2)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .en                         (en),
      .iFrame_Start               (iFrame_Start),
      .iPixel_Valid               (iPixel_Valid),
      .iPixel_X                   (iPixel_X),
      .iPixel_Y                   (iPixel_Y),
      .iBack_Color                (iBack_Color),
      .iCursor_Index              (iCursor_Index),
      .iActive_Periods_Num        (iActive_Periods_Num),
      .iPulseCounter_Gain_Divider (iPulseCounter_Gain_Divider),
      .oPixel_Valid               (oPixel_Valid),
      .oPixel_Color               (oPixel_Color),
      .oIn_Menu                   (oIn_Menu)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cur;
      logic [2:0]  per;
      logic [1:0]  dv;
      logic        en;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [15:0] bk;
      logic [15:0] col;
      logic        inm;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      iPixel_Valid = 1'b0;
      iPixel_X     = 10'd0;
      iPixel_Y     = 10'd0;
      iBack_Color  = 16'h0000;
   endtask

   // Frame pulse with en low (blink counter parked, cursor visible), then the
   // snapshot inputs are scrambled so only the latched values can matter.
   task automatic frame_start(input logic [3:0] c, input logic [2:0] p,
                              input logic [1:0] d, input logic en_after);
      en                         = 1'b0;
      iFrame_Start               = 1'b1;
      iCursor_Index              = c;
      iActive_Periods_Num        = p;
      iPulseCounter_Gain_Divider = d;
      @(posedge clk); #1;
      iFrame_Start               = 1'b0;
      iCursor_Index              = ~c;
      iActive_Periods_Num        = ~p;
      iPulseCounter_Gain_Divider = ~d;
      en                         = en_after;
   endtask

   // One pixel for one cycle, idle afterwards; sample after the 2nd edge.
   task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic [15:0] bk);
      iPixel_Valid = 1'b1;
      iPixel_X     = x;
      iPixel_Y     = y;
      iBack_Color  = bk;
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
   endtask

   task automatic expect_px(input string name, input logic [15:0] col, input logic inm);
      check({name, ".color"}, 32'(oPixel_Color), 32'(col));
      check({name, ".in_menu"}, 32'(oIn_Menu), 32'(inm));
      check({name, ".valid"}, 32'(oPixel_Valid), 32'd1);
   endtask

   initial begin
      //            cur    per    dv    en    x        y        bk        col       inm
      vecs[0]  = '{4'd3,  3'd0, 2'd0, 1'b1, 10'd141, 10'd250, 16'h001F, 16'hFFE0, 1'b1};
      vecs[1]  = '{4'd10, 3'd2, 2'd1, 1'b1, 10'd101, 10'd250, 16'h001F, 16'h07E0, 1'b1};
      vecs[2]  = '{4'd10, 3'd2, 2'd1, 1'b1, 10'd256, 10'd250, 16'h001F, 16'h07E0, 1'b1};
      vecs[3]  = '{4'd10, 3'd2, 2'd1, 1'b1, 10'd53,  10'd250, 16'h001F, 16'h001F, 1'b0};
      vecs[4]  = '{4'd10, 3'd2, 2'd1, 1'b1, 10'd418, 10'd250, 16'h001F, 16'hFFE0, 1'b1};
      vecs[5]  = '{4'd10, 3'd2, 2'd1, 1'b1, 10'd379, 10'd250, 16'h001F, 16'h8410, 1'b1};
      vecs[6]  = '{4'd15, 3'd6, 2'd3, 1'b1, 10'd260, 10'd250, 16'h0A0A, 16'h8410, 1'b1};
      vecs[7]  = '{4'd15, 3'd7, 2'd3, 1'b1, 10'd300, 10'd250, 16'h0A0A, 16'h8410, 1'b1};
      vecs[8]  = '{4'd15, 3'd6, 2'd3, 1'b1, 10'd340, 10'd250, 16'h0A0A, 16'h07E0, 1'b1};
      vecs[9]  = '{4'd15, 3'd6, 2'd3, 1'b1, 10'd20,  10'd250, 16'h0A0A, 16'h8410, 1'b1};
      vecs[10] = '{4'd3,  3'd0, 2'd0, 1'b1, 10'd141, 10'd239, 16'h1234, 16'h1234, 1'b0};
      vecs[11] = '{4'd3,  3'd0, 2'd0, 1'b1, 10'd141, 10'd263, 16'h1234, 16'hFFE0, 1'b1};
      vecs[12] = '{4'd3,  3'd0, 2'd0, 1'b1, 10'd141, 10'd264, 16'h1234, 16'h1234, 1'b0};
      vecs[13] = '{4'd0,  3'd1, 2'd2, 1'b1, 10'd15,  10'd250, 16'h5555, 16'h5555, 1'b0};
      vecs[14] = '{4'd0,  3'd1, 2'd2, 1'b1, 10'd16,  10'd250, 16'h5555, 16'hFFE0, 1'b1};
      vecs[15] = '{4'd4,  3'd1, 2'd2, 1'b1, 10'd51,  10'd250, 16'h5555, 16'h8410, 1'b1};
      vecs[16] = '{4'd4,  3'd1, 2'd2, 1'b1, 10'd52,  10'd250, 16'h5555, 16'h5555, 1'b0};
      vecs[17] = '{4'd10, 3'd1, 2'd2, 1'b1, 10'd451, 10'd250, 16'h5555, 16'hFFE0, 1'b1};
      vecs[18] = '{4'd10, 3'd1, 2'd2, 1'b1, 10'd452, 10'd250, 16'h5555, 16'h5555, 1'b0};
      vecs[19] = '{4'd10, 3'd1, 2'd2, 1'b1, 10'd456, 10'd250, 16'h5555, 16'h5555, 1'b0};
      vecs[20] = '{4'd3,  3'd0, 2'd0, 1'b0, 10'd141, 10'd250, 16'h00FF, 16'h00FF, 1'b0};
      vecs[21] = '{4'd2,  3'd2, 2'd0, 1'b1, 10'd101, 10'd250, 16'h3333, 16'hFFE0, 1'b1};

      rst = 1'b1;
      en = 1'b1;
      iFrame_Start = 1'b0;
      iCursor_Index = 4'd0;
      iActive_Periods_Num = 3'd0;
      iPulseCounter_Gain_Divider = 2'd0;
      idle_inputs();
      iPixel_Valid = 1'b1;
      iPixel_X = 10'd141;
      iPixel_Y = 10'd250;
      iBack_Color = 16'hBEEF;
      repeat (3) @(posedge clk);
      #1;
      check("reset.valid", 32'(oPixel_Valid), 32'd0);
      check("reset.color", 32'(oPixel_Color), 32'd0);
      check("reset.in_menu", 32'(oIn_Menu), 32'd0);
      rst = 1'b0;
      idle_inputs();

      // Table-driven vectors
      for (int i = 0; i < NV; i++) begin
         frame_start(vecs[i].cur, vecs[i].per, vecs[i].dv, vecs[i].en);
         pixel(vecs[i].x, vecs[i].y, vecs[i].bk);
         expect_px($sformatf("vec%0d", i), vecs[i].col, vecs[i].inm);
      end
      en = 1'b1;

      // Cursor input change mid-frame takes effect only at the next frame.
      frame_start(4'd3, 3'd4, 2'd3, 1'b1);
      iCursor_Index = 4'd7;
      pixel(10'd141, 10'd250, 16'h0101);
      expect_px("midframe.item3", 16'hFFE0, 1'b1);
      pixel(10'd301, 10'd250, 16'h0101);
      expect_px("midframe.item7", 16'h8410, 1'b1);
      frame_start(4'd7, 3'd4, 2'd3, 1'b1);
      pixel(10'd301, 10'd250, 16'h0101);
      expect_px("nextframe.item7", 16'hFFE0, 1'b1);
      pixel(10'd141, 10'd250, 16'h0101);
      expect_px("nextframe.item3", 16'h8410, 1'b1);

      // Frame start and pixel in the same cycle use the new snapshot.
      frame_start(4'd3, 3'd4, 2'd3, 1'b1);
      iFrame_Start  = 1'b1;
      iCursor_Index = 4'd5;
      pixel(10'd217, 10'd250, 16'h0202);
      iFrame_Start  = 1'b0;
      expect_px("same_cycle", 16'hFFE0, 1'b1);

      // Blink sequence: en held high from a parked counter.
      en = 1'b0;
      @(posedge clk); #1;
      en = 1'b1;
      for (int f = 0; f < 5; f++) begin
         logic [15:0] exp_col;
         iFrame_Start               = 1'b1;
         iCursor_Index              = 4'd0;
         iActive_Periods_Num        = 3'd4;
         iPulseCounter_Gain_Divider = 2'd3;
         @(posedge clk); #1;
         iFrame_Start = 1'b0;
`ifdef ZMENU_BLINK_EN
         exp_col = (f == 2 || f == 3) ? 16'h8410 : 16'hFFE0;
`else
         exp_col = 16'hFFE0;
`endif
         pixel(10'd20, 10'd250, 16'h0303);
         expect_px($sformatf("blink.frame%0d", f), exp_col, 1'b1);
      end

      // Reset mid-frame clears the in-flight pixel and the cursor snapshot.
      frame_start(4'd3, 3'd4, 2'd3, 1'b1);
      iPixel_Valid = 1'b1;
      iPixel_X     = 10'd141;
      iPixel_Y     = 10'd250;
      iBack_Color  = 16'h0404;
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst.valid", 32'(oPixel_Valid), 32'd0);
      check("midrst.color", 32'(oPixel_Color), 32'd0);
      check("midrst.in_menu", 32'(oIn_Menu), 32'd0);
      rst = 1'b0;
      pixel(10'd141, 10'd250, 16'h0404);
      expect_px("postrst.no_cursor", 16'h8410, 1'b1);
      pixel(10'd20, 10'd250, 16'h0404);
      expect_px("postrst.period0", 16'h07E0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
